// File: rtl/mc_seq_alu_pkg.sv
// Shared definitions for the multi-lane sequential ALU: opcode map,
// per-lane FSM state encoding and the flag bundle returned with each result.
package mc_seq_alu_pkg;

   localparam int OPC_W = 6;

   localparam logic [OPC_W-1:0] OP_ADD  = 6'd0;
   localparam logic [OPC_W-1:0] OP_SUB  = 6'd1;
   localparam logic [OPC_W-1:0] OP_AND  = 6'd2;
   localparam logic [OPC_W-1:0] OP_NAND = 6'd3;
   localparam logic [OPC_W-1:0] OP_OR   = 6'd4;
   localparam logic [OPC_W-1:0] OP_NOR  = 6'd5;
   localparam logic [OPC_W-1:0] OP_XOR  = 6'd6;
   localparam logic [OPC_W-1:0] OP_XNOR = 6'd7;
   localparam logic [OPC_W-1:0] OP_NOT  = 6'd8;
   localparam logic [OPC_W-1:0] OP_SRL  = 6'd9;
   localparam logic [OPC_W-1:0] OP_SLL  = 6'd10;
   localparam logic [OPC_W-1:0] OP_SRA  = 6'd11;
   localparam logic [OPC_W-1:0] OP_SLA  = 6'd12;
   localparam logic [OPC_W-1:0] OP_INC  = 6'd13;
   localparam logic [OPC_W-1:0] OP_DEC  = 6'd14;
   localparam logic [OPC_W-1:0] OP_CE   = 6'd15;
   localparam logic [OPC_W-1:0] OP_CBE  = 6'd16;
   localparam logic [OPC_W-1:0] OP_CAE  = 6'd17;
   localparam logic [OPC_W-1:0] OP_CB   = 6'd18;
   localparam logic [OPC_W-1:0] OP_CA   = 6'd19;
   localparam logic [OPC_W-1:0] OP_CNE  = 6'd20;
   localparam logic [OPC_W-1:0] OP_MUL  = 6'd21;
   localparam logic [OPC_W-1:0] OP_DIV  = 6'd22;
   localparam logic [OPC_W-1:0] OP_MOD  = 6'd23;
   // Reserved codes: decoded as illegal by every lane.
   localparam logic [OPC_W-1:0] OP_PWR  = 6'd24;
   localparam logic [OPC_W-1:0] OP_FACT = 6'd25;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } lane_state_e;

   typedef struct packed {
      logic zero;
      logic compare;
      logic par_odd;
      logic par_even;
      logic overflow;
      logic divzero;
      logic illegal;
   } flags_t;

endpackage

// File: rtl/mc_seq_alu_if.sv
// Request/response bundle for all ALU lanes; every vector carries one slice per lane.
interface mc_seq_alu_if #(
   parameter int W   = 64,
   parameter int NCH = 4
);
   logic [NCH-1:0]   in_valid;
   logic [NCH-1:0]   in_ready;
   logic [NCH*6-1:0] Function;
   logic [NCH*W-1:0] input1;
   logic [NCH*W-1:0] input2;
   logic [NCH-1:0]   out_valid;
   logic [NCH-1:0]   out_ready;
   logic [NCH*W-1:0] result;
   logic [NCH*W-1:0] result_hi;
   logic [NCH-1:0]   Zero;
   logic [NCH-1:0]   Compare;
   logic [NCH-1:0]   Parity_ODD;
   logic [NCH-1:0]   Parity_EVEN;
   logic [NCH-1:0]   Overflow;
   logic [NCH-1:0]   DivZero;
   logic [NCH-1:0]   Illegal;

   modport master (
      output in_valid, Function, input1, input2, out_ready,
      input  in_ready, out_valid, result, result_hi,
             Zero, Compare, Parity_ODD, Parity_EVEN, Overflow, DivZero, Illegal
   );

   modport slave (
      input  in_valid, Function, input1, input2, out_ready,
      output in_ready, out_valid, result, result_hi,
             Zero, Compare, Parity_ODD, Parity_EVEN, Overflow, DivZero, Illegal
   );
endinterface

// File: rtl/mc_seq_alu_lane.sv
// One independent ALU lane: single-cycle logic/arith/compare ops,
// iterative shift-add MUL and restoring DIV/MOD, held result until consumed.
module alu_lane
   import mc_seq_alu_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [5:0]   func_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] result_o,
   output logic [W-1:0] result_hi_o,
   output flags_t       flags_o
);

   localparam int CW = $clog2(W + 1);

   lane_state_e  state_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [5:0]   op_q;
   logic [W-1:0] b_q;       // multiplicand (MUL) or divisor (DIV/MOD)
   logic [W-1:0] hi_q;      // product high half or partial remainder
   logic [W-1:0] lo_q;      // multiplier/product low half or dividend/quotient
   logic [CW-1:0] cnt_q;
   logic [W-1:0] res_q;
   logic [W-1:0] res_hi_q;
   flags_t       flg_q;

   logic [W-1:0] sc_res_d;
   logic         sc_cmp_d;
   logic         sc_ovf_d;
   logic         sc_dz_d;
   logic         sc_ill_d;
   logic         sc_multi_d;

   logic [W:0]   mul_sum;
   logic [W:0]   div_sh;
   logic [W-1:0] div_diff;
   logic         div_ge;
   logic [W-1:0] step_hi_d;
   logic [W-1:0] step_lo_d;

   function automatic flags_t mk_flags(input logic [W-1:0] r, input logic cmp,
                                       input logic ovf, input logic dz, input logic ill);
      flags_t f;
      f.zero     = (r == '0);
      f.compare  = cmp;
      f.par_odd  = r[0];
      f.par_even = ~r[0];
      f.overflow = ovf;
      f.divzero  = dz;
      f.illegal  = ill;
      return f;
   endfunction

   // Decode the live request into a one-cycle result, or flag it as iterative.
   always_comb begin
      sc_res_d   = '0;
      sc_cmp_d   = 1'b0;
      sc_ovf_d   = 1'b0;
      sc_dz_d    = 1'b0;
      sc_ill_d   = 1'b0;
      sc_multi_d = 1'b0;
      case (func_i)
         OP_ADD:  {sc_ovf_d, sc_res_d} = {1'b0, a_i} + {1'b0, b_i};
         OP_SUB:  {sc_ovf_d, sc_res_d} = {1'b0, a_i} - {1'b0, b_i};
         OP_INC:  {sc_ovf_d, sc_res_d} = {1'b0, a_i} + (W+1)'(1);
         OP_DEC:  {sc_ovf_d, sc_res_d} = {1'b0, a_i} - (W+1)'(1);
         OP_AND:  sc_res_d = a_i & b_i;
         OP_NAND: sc_res_d = ~(a_i & b_i);
         OP_OR:   sc_res_d = a_i | b_i;
         OP_NOR:  sc_res_d = ~(a_i | b_i);
         OP_XOR:  sc_res_d = a_i ^ b_i;
         OP_XNOR: sc_res_d = ~(a_i ^ b_i);
         OP_NOT:  sc_res_d = ~a_i;
         OP_SRL:  sc_res_d = {1'b0, a_i[W-1:1]};
         OP_SRA:  sc_res_d = {a_i[W-1], a_i[W-1:1]};
         OP_SLL,
         OP_SLA:  sc_res_d = {a_i[W-2:0], 1'b0};
         OP_CE:   begin sc_res_d = a_i; sc_cmp_d = (a_i == b_i); end
         OP_CBE:  begin sc_res_d = a_i; sc_cmp_d = (a_i <= b_i); end
         OP_CAE:  begin sc_res_d = a_i; sc_cmp_d = (a_i >= b_i); end
         OP_CB:   begin sc_res_d = a_i; sc_cmp_d = (a_i <  b_i); end
         OP_CA:   begin sc_res_d = a_i; sc_cmp_d = (a_i >  b_i); end
         OP_CNE:  begin sc_res_d = a_i; sc_cmp_d = (a_i != b_i); end
         OP_MUL:  sc_multi_d = 1'b1;
         OP_DIV:  begin
            if (b_i == '0) begin
               sc_dz_d  = 1'b1;
               sc_res_d = '1;
            end else begin
               sc_multi_d = 1'b1;
            end
         end
         OP_MOD:  begin
            if (b_i == '0) begin
               sc_dz_d  = 1'b1;
               sc_res_d = a_i;
            end else begin
               sc_multi_d = 1'b1;
            end
         end
         default: sc_ill_d = 1'b1;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide on the captured operands.
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {hi_q, lo_q[W-1]};
      div_ge   = (div_sh >= {1'b0, b_q});
      // When div_ge holds the true difference is below b_q, so W bits suffice.
      div_diff = div_sh[W-1:0] - b_q;
      if (op_q == OP_MUL) begin
         step_hi_d = mul_sum[W:1];
         step_lo_d = {mul_sum[0], lo_q[W-1:1]};
      end else begin
         step_hi_d = div_ge ? div_diff : div_sh[W-1:0];
         step_lo_d = {lo_q[W-2:0], div_ge};
      end
   end

   // Lane FSM with registered handshake, result and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         op_q        <= '0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         res_hi_q    <= '0;
         flg_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  op_q       <= func_i;
                  b_q        <= b_i;
                  hi_q       <= '0;
                  lo_q       <= a_i;
                  cnt_q      <= CW'(W);
                  in_ready_q <= 1'b0;
                  if (sc_multi_d) begin
                     state_q <= S_BUSY;
                  end else begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     res_q       <= sc_res_d;
                     res_hi_q    <= '0;
                     flg_q       <= mk_flags(sc_res_d, sc_cmp_d, sc_ovf_d, sc_dz_d, sc_ill_d);
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            S_BUSY: begin
               hi_q  <= step_hi_d;
               lo_q  <= step_lo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  if (op_q == OP_MUL) begin
                     res_q    <= step_lo_d;
                     res_hi_q <= step_hi_d;
                     flg_q    <= mk_flags(step_lo_d, 1'b0, (step_hi_d != '0), 1'b0, 1'b0);
                  end else if (op_q == OP_MOD) begin
                     res_q    <= step_hi_d;
                     res_hi_q <= '0;
                     flg_q    <= mk_flags(step_hi_d, 1'b0, 1'b0, 1'b0, 1'b0);
                  end else begin
                     res_q    <= step_lo_d;
                     res_hi_q <= '0;
                     flg_q    <= mk_flags(step_lo_d, 1'b0, 1'b0, 1'b0, 1'b0);
                  end
               end
            end
            S_DONE: begin
               // Leaving DONE never accepts a new request on the same edge.
               if (out_ready_i) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = res_q;
   assign result_hi_o = res_hi_q;
   assign flags_o     = flg_q;

endmodule

// File: rtl/mc_seq_alu.sv
// Multi-lane sequential ALU: NCH independent lanes sharing one clock and reset.
module mc_seq_alu
   import mc_seq_alu_pkg::*;
#(
   parameter int W   = 64,
   parameter int NCH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mc_seq_alu_if.slave  bus
);

   logic         rdy_a [NCH];
   logic         vld_a [NCH];
   logic [W-1:0] res_a [NCH];
   logic [W-1:0] rhi_a [NCH];
   flags_t       flg_a [NCH];

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      alu_lane #(.W(W)) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_valid_i  (bus.in_valid[k]),
         .in_ready_o  (rdy_a[k]),
         .func_i      (bus.Function[k*6 +: 6]),
         .a_i         (bus.input1[k*W +: W]),
         .b_i         (bus.input2[k*W +: W]),
         .out_valid_o (vld_a[k]),
         .out_ready_i (bus.out_ready[k]),
         .result_o    (res_a[k]),
         .result_hi_o (rhi_a[k]),
         .flags_o     (flg_a[k])
      );
   end

   // Pack per-lane outputs into the shared vector bus.
   always_comb begin
      bus.in_ready    = '0;
      bus.out_valid   = '0;
      bus.result      = '0;
      bus.result_hi   = '0;
      bus.Zero        = '0;
      bus.Compare     = '0;
      bus.Parity_ODD  = '0;
      bus.Parity_EVEN = '0;
      bus.Overflow    = '0;
      bus.DivZero     = '0;
      bus.Illegal     = '0;
      for (int k = 0; k < NCH; k++) begin
         bus.in_ready[k]         = rdy_a[k];
         bus.out_valid[k]        = vld_a[k];
         bus.result[k*W +: W]    = res_a[k];
         bus.result_hi[k*W +: W] = rhi_a[k];
         bus.Zero[k]             = flg_a[k].zero;
         bus.Compare[k]          = flg_a[k].compare;
         bus.Parity_ODD[k]       = flg_a[k].par_odd;
         bus.Parity_EVEN[k]      = flg_a[k].par_even;
         bus.Overflow[k]         = flg_a[k].overflow;
         bus.DivZero[k]          = flg_a[k].divzero;
         bus.Illegal[k]          = flg_a[k].illegal;
      end
   end

endmodule
